// File: rtl/mem_responder_if.sv
// mem_responder_if: load/store channel between a processor MEM stage
// (master) and a data memory responder (slave).
//
// Handshake: each channel transfers on a rising clk1 edge where its valid
// and ready are both high. A master holds req_* stable while req_valid is
// high and req_ready is low; the slave holds rsp_* stable while rsp_valid is
// high and rsp_ready is low. Neither side may make valid depend on ready.
//
// Signals:
//   req_valid/req_ready  request channel handshake
//   req_we               1 = store, 0 = load
//   req_addr             word address
//   req_wdata            store data
//   rsp_valid/rsp_ready  response channel handshake
//   rsp_rdata            load data (0 for stores and errors)
//   rsp_err              address was out of range
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port word-addressed data memory with a programmable
// access latency. Accepts one load/store at a time, waits LATENCY cycles,
// performs the access and returns the result until the requester takes it.
//
// Ports:
//   clk1       clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset (memory contents are kept)
//   bus        mem_responder_if.slave request/response channels
//   busy       high whenever the FSM is not IDLE
//   state_dbg  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic           clk1,
    input  logic           rst_n,
    mem_responder_if.slave bus,
    output logic           busy,
    output logic [1:0]     state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        hold_we;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          rsp_done;
    logic          access_now;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_ok;
    logic [AW-1:0] acc_idx;

    assign accept    = bus.req_valid && bus.req_ready;
    assign rsp_done  = bus.rsp_valid && bus.rsp_ready;
    assign state_dbg = state;

    // The access happens on the edge that enters RESP. With zero latency
    // that is the accepting edge itself, so the live request fields are used
    // instead of the (not yet loaded) holding registers.
    always_comb begin
        access_now = 1'b0;
        acc_we     = hold_we;
        acc_addr   = hold_addr;
        acc_wdata  = hold_wdata;
        if (state == IDLE) begin
            access_now = accept && (LATENCY == 0);
            acc_we     = bus.req_we;
            acc_addr   = bus.req_addr;
            acc_wdata  = bus.req_wdata;
        end else if (state == WAIT) begin
            access_now = (wait_cnt == 4'd0);
        end
    end

    // Full 32-bit compare so any nonzero upper bit flags an error.
    assign acc_ok  = (acc_addr < 32'(DEPTH));
    assign acc_idx = acc_addr[AW-1:0];

    // Memory array has no reset; only in-range stores reach it.
    always_ff @(posedge clk1) begin
        if (access_now && acc_we && acc_ok) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= 4'd0;
            hold_we       <= 1'b0;
            hold_addr     <= 32'd0;
            hold_wdata    <= 32'd0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            if (access_now) begin
                state         <= RESP;
                bus.req_ready <= 1'b0;
                bus.rsp_valid <= 1'b1;
                busy          <= 1'b1;
                bus.rsp_err   <= !acc_ok;
                bus.rsp_rdata <= (acc_ok && !acc_we) ? mem[acc_idx] : 32'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            hold_we       <= bus.req_we;
                            hold_addr     <= bus.req_addr;
                            hold_wdata    <= bus.req_wdata;
                            state         <= WAIT;
                            bus.req_ready <= 1'b0;
                            busy          <= 1'b1;
                            // WAIT lasts LATENCY cycles including the one
                            // where the counter reads zero.
                            wait_cnt      <= 4'(LATENCY - 1);
                        end
                    end
                    WAIT: begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                    RESP: begin
                        if (rsp_done) begin
                            state         <= IDLE;
                            bus.req_ready <= 1'b1;
                            bus.rsp_valid <= 1'b0;
                            bus.rsp_rdata <= 32'd0;
                            bus.rsp_err   <= 1'b0;
                            busy          <= 1'b0;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        bus.req_ready <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                        busy          <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. Three instances share
// clk1: d0 LATENCY=2, d1 LATENCY=0, d2 LATENCY=4 (own reset for the
// mid-transaction reset case). Inputs change on the falling edge, outputs
// are sampled on the falling edge.
module tb_mem_responder;
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic [2:0]        rst_n;
    logic [2:0]        req_valid;
    logic [2:0]        req_we;
    logic [2:0]        rsp_ready;
    logic [2:0][31:0]  req_addr;
    logic [2:0][31:0]  req_wdata;
    logic [2:0]        req_ready_o;
    logic [2:0]        rsp_valid_o;
    logic [2:0]        rsp_err_o;
    logic [2:0]        busy_o;
    logic [2:0][31:0]  rsp_rdata_o;
    logic [2:0][1:0]   state_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    logic        b2b_we   [6];
    logic [31:0] b2b_addr [6];
    logic [31:0] b2b_data [6];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 0 : 4);
        mem_responder_if bus();
        assign bus.req_valid   = req_valid[g];
        assign bus.req_we      = req_we[g];
        assign bus.req_addr    = req_addr[g];
        assign bus.req_wdata   = req_wdata[g];
        assign bus.rsp_ready   = rsp_ready[g];
        assign req_ready_o[g]  = bus.req_ready;
        assign rsp_valid_o[g]  = bus.rsp_valid;
        assign rsp_err_o[g]    = bus.rsp_err;
        assign rsp_rdata_o[g]  = bus.rsp_rdata;
        mem_responder #(.DEPTH(1024), .AW(10), .LATENCY(LAT)) dut (
            .clk1      (clk1),
            .rst_n     (rst_n[g]),
            .bus       (bus.slave),
            .busy      (busy_o[g]),
            .state_dbg (state_o[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready_o[i]), 32'd1);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid_o[i]), 32'd0);
        chk({tag, ".rdata"}, rsp_rdata_o[i], 32'd0);
        chk({tag, ".err"}, 32'(rsp_err_o[i]), 32'd0);
        chk({tag, ".busy"}, 32'(busy_o[i]), 32'd0);
    endtask

    // One full transaction with rsp_ready held high; checks latency, data,
    // error flag and the return to idle.
    task automatic txn(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_e, input int lat);
        int k;
        logic [31:0] e;
        string t;
        t = $sformatf("d%0d.%s@%0h", i, we ? "wr" : "rd", addr);
        @(negedge clk1);
        chk({t, ".ready_before"}, 32'(req_ready_o[i]), 32'd1);
        exp_q.push_back(exp_data);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        rsp_ready[i] = 1'b1;
        @(negedge clk1);
        req_valid[i] = 1'b0;
        chk({t, ".busy"}, 32'(busy_o[i]), 32'd1);
        chk({t, ".ready_low"}, 32'(req_ready_o[i]), 32'd0);
        k = 1;
        while (!rsp_valid_o[i] && k <= 20) begin
            @(negedge clk1);
            k++;
        end
        chk({t, ".latency"}, 32'(k), 32'(lat + 1));
        e = exp_q.pop_front();
        chk({t, ".rdata"}, rsp_rdata_o[i], e);
        chk({t, ".err"}, 32'(rsp_err_o[i]), 32'(exp_e));
        @(negedge clk1);
        chk_idle(i, {t, ".after"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 3'b000;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = 3'b111;
        req_addr  = '0;
        req_wdata = '0;
        b2b_we    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        b2b_addr  = '{32'd1, 32'd2, 32'd3, 32'd1, 32'd2, 32'd3};
        b2b_data  = '{32'h11111111, 32'h22222222, 32'h33333333,
                      32'h11111111, 32'h22222222, 32'h33333333};

        // Reset values.
        repeat (2) @(negedge clk1);
        for (int g = 0; g < 3; g++) chk_idle(g, $sformatf("d%0d.reset", g));
        rst_n = 3'b111;
        @(negedge clk1);
        for (int g = 0; g < 3; g++) chk({$sformatf("d%0d.state_idle", g)}, 32'(state_o[g]), 32'd0);

        // LATENCY=2: write then read address 5.
        txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, 2);
        txn(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 2);
        txn(0, 1'b1, 32'd9, 32'h00000099, 32'd0, 1'b0, 2);

        // LATENCY=0: back-to-back with req_valid held high.
        @(negedge clk1);
        req_valid[1] = 1'b1;
        req_we[1]    = b2b_we[0];
        req_addr[1]  = b2b_addr[0];
        req_wdata[1] = b2b_data[0];
        for (int j = 0; j < 12; j++) begin
            chk($sformatf("b2b.req_ready[%0d]", j), 32'(req_ready_o[1]), 32'(j % 2 == 0));
            chk($sformatf("b2b.rsp_valid[%0d]", j), 32'(rsp_valid_o[1]), 32'(j % 2 == 1));
            if (j % 2 == 1) begin
                chk($sformatf("b2b.rdata[%0d]", j / 2), rsp_rdata_o[1],
                    b2b_we[j / 2] ? 32'd0 : b2b_data[j / 2]);
                if (j / 2 + 1 < 6) begin
                    req_we[1]    = b2b_we[j / 2 + 1];
                    req_addr[1]  = b2b_addr[j / 2 + 1];
                    req_wdata[1] = b2b_data[j / 2 + 1];
                end else begin
                    req_valid[1] = 1'b0;
                end
            end
            @(negedge clk1);
        end
        chk_idle(1, "b2b.end");

        // Backpressure: read 5 with rsp_ready low; stray write pulses to 9.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'd5;
        rsp_ready[0] = 1'b0;
        @(negedge clk1);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp.rsp_valid[%0d]", i), 32'(rsp_valid_o[0]), 32'd1);
            chk($sformatf("bp.rdata[%0d]", i), rsp_rdata_o[0], 32'hDEADBEEF);
            chk($sformatf("bp.req_ready[%0d]", i), 32'(req_ready_o[0]), 32'd0);
            req_valid[0] = (i % 2 == 0) && (i < 9);
            req_we[0]    = 1'b1;
            req_addr[0]  = 32'd9;
            req_wdata[0] = 32'h00000BAD;
            if (i == 9) rsp_ready[0] = 1'b1;
            @(negedge clk1);
        end
        chk_idle(0, "bp.done");
        txn(0, 1'b0, 32'd9, 32'd0, 32'h00000099, 1'b0, 2);

        // Out of range accesses.
        txn(0, 1'b1, 32'd1024, 32'h1, 32'd0, 1'b1, 2);
        txn(0, 1'b0, 32'h80000005, 32'd0, 32'd0, 1'b1, 2);
        txn(0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 2);

        // Boundary addresses.
        txn(0, 1'b1, 32'd1023, 32'hFFFFFFFF, 32'd0, 1'b0, 2);
        txn(0, 1'b0, 32'd1023, 32'd0, 32'hFFFFFFFF, 1'b0, 2);
        txn(0, 1'b1, 32'd0, 32'h0, 32'd0, 1'b0, 2);
        txn(0, 1'b0, 32'd0, 32'd0, 32'h0, 1'b0, 2);
        txn(0, 1'b0, 32'd1023, 32'd0, 32'hFFFFFFFF, 1'b0, 2);

        // LATENCY=4: reset while a write to 7 is waiting.
        txn(2, 1'b1, 32'd7, 32'hA5A5A5A5, 32'd0, 1'b0, 4);
        txn(2, 1'b0, 32'd7, 32'd0, 32'hA5A5A5A5, 1'b0, 4);
        @(negedge clk1);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'd7;
        req_wdata[2] = 32'h00001234;
        @(negedge clk1);
        req_valid[2] = 1'b0;
        chk("rst.state_wait", 32'(state_o[2]), 32'd1);
        #2 rst_n[2] = 1'b0;
        #1;
        chk_idle(2, "rst.async");
        chk("rst.state_idle", 32'(state_o[2]), 32'd0);
        @(negedge clk1);
        rst_n[2] = 1'b1;
        txn(2, 1'b0, 32'd7, 32'd0, 32'hA5A5A5A5, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-port word-addressed data memory responder: the target end of the load/store interface issued by the pipelined processor's MEM stage.
- Accepts one read (LW) or write (SW) request at a time over a valid/ready request channel.
- Applies a programmable access latency, then returns data or a write acknowledge over a valid/ready response channel.
- Lets the core's data memory be a separate block with realistic wait states instead of an internal array.

Parameters:
- DEPTH, 1024, number of 32-bit words; legal addresses are 0..DEPTH-1.
- AW, 10, index width used internally; must equal clog2(DEPTH).
- LATENCY, 2, wait cycles between request acceptance and response assertion; legal range 0..15.

Ports:
- clk1  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write (store), 0 = read (load).
- req_addr  input  32  word address (not byte address).
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for writes and for errors.
- rsp_err  output  1  address was out of range.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state returns to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; wait counter=0.
  - Memory array contents are NOT reset.
- Request transfer: a request is accepted on a clk1 edge where req_valid && req_ready. req_we, req_addr and req_wdata are captured into holding registers at that edge.
- FSM states:
  - IDLE: req_ready=1. On acceptance, go to WAIT if LATENCY>0, else go to RESP.
  - WAIT: req_ready=0. The counter loads LATENCY-1 on acceptance and decrements each cycle. When the counter equals 0, perform the access and go to RESP.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready on an edge, then go to IDLE.
- The memory access happens on the edge that enters RESP:
  - read: rsp_rdata <= mem[addr].
  - write: mem[addr] <= wdata and rsp_rdata <= 0.
- Latency: the response is visible exactly LATENCY+1 cycles after the accepting edge. With LATENCY=0, rsp_valid is high the cycle after acceptance.
- Single outstanding transaction. No new request is accepted in the same cycle a response completes; req_ready rises the cycle after the response handshake. Minimum throughput is one transaction per LATENCY+2 cycles.
- Out of range (req_addr >= DEPTH, any upper bits nonzero):
  - no memory write; rsp_err=1; rsp_rdata=0.
  - The latency is the same as for a legal access.
- Backpressure: if rsp_ready is low, stay in RESP indefinitely with outputs unchanged.
- Inputs while not ready: req_valid and request fields are ignored while req_ready=0. No queueing, no error.
- Read after write: a read accepted after a write's response handshake returns the written value.
- Reset mid-transaction: any in-flight request is dropped.
  - A write whose access edge has not occurred does not modify memory.
  - A write whose access edge occurred is retained.
- rsp_err and rsp_rdata clear to 0 on the edge that returns to IDLE.

Test Plan:
- LATENCY=2: write addr 5 data 0xDEADBEEF, then read addr 5 -> write response at cycle +3 with rsp_err=0 and rdata=0; read response at cycle +3 with rdata=0xDEADBEEF.
- LATENCY=0: back-to-back requests with req_valid held high, addrs 1,2,3, rsp_ready=1 -> rsp_valid is high the cycle after each acceptance; req_ready pattern is 1,0,1,0,...
- Backpressure: read addr 5 with rsp_ready held low for 10 cycles -> rsp_valid and rdata=0xDEADBEEF stable for all 10 cycles; req_valid pulses during that window are not accepted; completes on the first rsp_ready=1.
- Error: write addr 1024 data 0x1, then read addr 0x80000005 -> both respond with rsp_err=1 and rdata=0; a later read of addr 5 still returns 0xDEADBEEF.
- Reset during WAIT: write addr 7 data 0x1234 (LATENCY=4), pulse rst_n low after 1 cycle -> outputs go to reset values immediately; a subsequent read of addr 7 returns its pre-write value.
- Boundary: write and read addr 1023 data 0xFFFFFFFF, and addr 0 data 0x0 -> correct data with rsp_err=0.
